wb_uart_tx: RTL and testbench
=============================

Name: wb_uart_tx

Overview:
- Byte-wide UART transmitter, 8N1 framing, LSB first. It is the transmit counterpart of the Wishbone UART receiver.
- The CPU-side bridge pushes bytes over a reduced Wishbone write port into an internal FIFO.
- A baud-rate FSM drains the FIFO and serialises each byte onto uart_tx.
- It sits beside the RX block on the same peripheral bus.

Parameters:
- FIFO_AW, 5: FIFO address width. Depth is 2**FIFO_AW = 32 entries.
- BAUD_DIV_RATE, 2604: i_clk cycles per UART bit. Legal range is ≥2 and < 2**BAUD_DIV_WIDTH.
- BAUD_DIV_WIDTH, 12: width of the baud counter.

Ports:
- i_clk  in  1  system clock; all logic on its rising edge
- i_reset_n  in  1  synchronous, active-low reset
- i_wb_cyc  in  1  bus cycle qualifier
- i_wb_stb  in  1  write strobe; every strobe is a write
- i_wb_data  in  8  byte to transmit
- o_wb_ack  out  1  one-cycle acknowledge of an accepted write
- o_wb_stall  out  1  FIFO full; the write is not accepted
- uart_tx  out  1  serial line, idle high
- uart_full  out  1  FIFO full flag
- uart_busy  out  1  FIFO non-empty or frame in progress

Behaviour:
- Reset (i_reset_n=0 at an edge):
  - FIFO cleared (count 0), state IDLE, baud and bit counters 0.
  - o_wb_ack=0, uart_tx=1, uart_full=0, uart_busy=0.
  - Reset mid-frame aborts the frame: uart_tx=1 from the next edge, and the in-flight byte and all queued bytes are discarded.
- Write handshake:
  - o_wb_stall = uart_full, combinational from registered FIFO count.
  - Accept when i_wb_cyc && i_wb_stb && !o_wb_stall. i_wb_data is written at that edge.
  - o_wb_ack is registered: high exactly one cycle after each acceptance, otherwise 0.
  - Stalled or cyc-less strobes produce no ack and no write.
  - Back-to-back strobes are accepted every cycle while not full.
- FIFO:
  - Circular buffer with FIFO_AW-bit read/write pointers and a (FIFO_AW+1)-bit count. Pointers wrap modulo depth.
  - Push and pop in the same cycle leaves count unchanged.
  - A push while full is impossible because stall holds it off, even if a pop occurs in that cycle.
  - uart_full = (count == depth).
- FSM states: IDLE, LOAD, START, DATA, STOP.
  - IDLE: uart_tx=1. If count≠0, go to LOAD at the next edge.
  - LOAD (1 cycle): pop the FIFO head into an 8-bit shift register. Clear the baud counter. Go to START.
  - START: uart_tx=0 (registered). Hold BAUD_DIV_RATE cycles, then go to DATA with bit counter = 0.
  - DATA: uart_tx = shift[0]. At each bit-period end, shift right and increment the bit counter. After bit 7's period, go to STOP.
  - STOP: uart_tx=1 for BAUD_DIV_RATE cycles, then go to IDLE.
  - Illegal state encodings go to IDLE.
- Baud counter: counts 0..BAUD_DIV_RATE-1 inside START/DATA/STOP. Terminal count ends the bit period and wraps to 0.
- Timing: write accepted at edge E0 with the FSM idle and FIFO empty. Then:
  - LOAD at E1.
  - uart_tx falls at E2.
  - Data bit i occupies [E2+(i+1)N, E2+(i+2)N), with N=BAUD_DIV_RATE.
  - Stop bit occupies [E2+9N, E2+10N).
  - IDLE at E2+10N.
  - With the FIFO non-empty, the next start bit begins at E2+10N+2. This gives a fixed 2-cycle inter-frame gap.
- uart_busy = (state≠IDLE) || (count≠0).

Test Plan:
- Reset, then idle 50 cycles -> uart_tx=1, o_wb_ack=0, o_wb_stall=0, uart_busy=0 throughout.
- N=5, single write 0xA5 at E0 -> ack high only at E0+1; uart_tx low E2..E2+4; data bits 1,0,1,0,0,1,0,1, 5 cycles each; high from E2+45; uart_busy falls at E2+50.
- N=5, write 0x00 then 0xFF on consecutive cycles -> two frames; second start bit at E2+52; both stop bits high; decoded bytes 0x00, 0xFF.
- Write 34 bytes back-to-back from empty (stb held) -> 33 acks; stall asserted from the 34th attempt; uart_full=1; bytes then emerge in order with FIFO wrap-around verified; stall drops after the next LOAD pop.
- i_wb_stb=1 with i_wb_cyc=0 -> no ack, FIFO count unchanged, uart_tx stays 1.
- Reset asserted during DATA bit 3 of 0x3C with 4 bytes queued -> uart_tx=1 next edge; uart_busy=0; no further frames after reset release.

Source files
------------

// File: rtl/wb_uart_tx.sv
// wb_uart_tx: byte-wide 8N1 UART transmitter (LSB first) fed through a reduced
// Wishbone write port and a circular FIFO.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_reset_n   synchronous active-low reset
//   i_wb_cyc    bus cycle qualifier
//   i_wb_stb    write strobe (every strobe is a write)
//   i_wb_data   byte to queue for transmission
//   o_wb_ack    registered one-cycle acknowledge of an accepted write
//   o_wb_stall  high while the FIFO is full; the write is not accepted
//   uart_tx     serial line, idle high
//   uart_full   FIFO full flag
//   uart_busy   FIFO non-empty or a frame is in progress
module wb_uart_tx #(
  parameter int FIFO_AW        = 5,
  parameter int BAUD_DIV_RATE  = 2604,
  parameter int BAUD_DIV_WIDTH = 12
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_wb_cyc,
  input  logic       i_wb_stb,
  input  logic [7:0] i_wb_data,
  output logic       o_wb_ack,
  output logic       o_wb_stall,
  output logic       uart_tx,
  output logic       uart_full,
  output logic       uart_busy
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]          FULL_COUNT = (FIFO_AW + 1)'(DEPTH);
  localparam logic [BAUD_DIV_WIDTH-1:0] BAUD_LAST  = BAUD_DIV_WIDTH'(BAUD_DIV_RATE - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [7:0]                mem_q [DEPTH];
  logic [FIFO_AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]          count_q, count_d;
  logic [2:0]                state_q, state_d;
  logic [BAUD_DIV_WIDTH-1:0] baud_q, baud_d;
  logic [2:0]                bit_q, bit_d;
  logic [7:0]                shift_q, shift_d;
  logic                      tx_q, tx_d;
  logic                      ack_q;

  logic push;
  logic pop;
  logic baud_tick;

  assign uart_full  = (count_q == FULL_COUNT);
  assign o_wb_stall = uart_full;
  assign push       = i_wb_cyc && i_wb_stb && !uart_full;
  // The head byte leaves the FIFO during the single LOAD cycle.
  assign pop        = (state_q == S_LOAD);
  assign baud_tick  = (baud_q == BAUD_LAST);
  assign uart_busy  = (state_q != S_IDLE) || (count_q != '0);
  assign uart_tx    = tx_q;
  assign o_wb_ack   = ack_q;

  // FIFO pointer and occupancy bookkeeping; pointers wrap naturally.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Transmit FSM. The line is registered, so tx_d is derived from the state
  // being entered, which puts the start bit on the line at the LOAD->START edge.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) state_d = S_LOAD;
      end
      S_LOAD: begin
        shift_d = mem_q[rd_ptr_q];
        baud_d  = '0;
        state_d = S_START;
      end
      S_START: begin
        if (baud_tick) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Storage and shift register carry data only; they need no reset because
  // nothing reads them before a push or a LOAD has written them.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_wb_data;
    shift_q <= shift_d;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      ack_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      ack_q    <= push;
    end
  end

endmodule

// File: tb/tb_wb_uart_tx.sv
// Testbench for wb_uart_tx with a short baud divisor.
module tb_wb_uart_tx;
  localparam int N     = 5;
  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;
  localparam int FRAME = 10 * N + 2;  // start-to-start spacing of queued frames

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       wb_cyc  = 1'b0;
  logic       wb_stb  = 1'b0;
  logic [7:0] wb_data = 8'h00;
  logic       ack, stall, tx, full, busy;

  int checks = 0;
  int errors = 0;

  logic line_buf [0:2047];

  wb_uart_tx #(
    .FIFO_AW       (AW),
    .BAUD_DIV_RATE (N),
    .BAUD_DIV_WIDTH(12)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_wb_cyc  (wb_cyc),
    .i_wb_stb  (wb_stb),
    .i_wb_data (wb_data),
    .o_wb_ack  (ack),
    .o_wb_stall(stall),
    .uart_tx   (tx),
    .uart_full (full),
    .uart_busy (busy)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of accepted bytes with their acceptance edge.
  // A byte starts its frame at max(accept_edge + 2, previous_start + 10N + 2);
  // the line is then a 10-slot frame {stop, data[7:0], start} of N cycles each.
  int         cyc_cnt = 0;
  logic [7:0] mq_data [$];
  int         mq_edge [$];
  logic [7:0] cur_byte   = 8'h00;
  int         last_pop   = -100000;
  bit         have_frame = 1'b0;
  logic       exp_tx = 1'b1, exp_ack = 1'b0, exp_busy = 1'b0, exp_full = 1'b0;

  initial begin : model
    int off, slot;
    bit in_frame;
    forever begin
      @(posedge clk);
      cyc_cnt++;
      exp_ack = 1'b0;
      if (!rst_n) begin
        mq_data.delete();
        mq_edge.delete();
        have_frame = 1'b0;
        last_pop   = -100000;
      end else begin
        if (wb_cyc && wb_stb && mq_data.size() < DEPTH) begin
          mq_data.push_back(wb_data);
          mq_edge.push_back(cyc_cnt);
          exp_ack = 1'b1;
        end
        if (mq_data.size() > 0 && cyc_cnt >= mq_edge[0] + 2 &&
            cyc_cnt >= last_pop + 10 * N + 2) begin
          cur_byte = mq_data.pop_front();
          void'(mq_edge.pop_front());
          last_pop   = cyc_cnt;
          have_frame = 1'b1;
        end
      end
      off      = cyc_cnt - last_pop;
      in_frame = have_frame && off < 10 * N;
      exp_tx   = 1'b1;
      if (in_frame) begin
        slot = off / N;
        if (slot == 0)      exp_tx = 1'b0;
        else if (slot <= 8) exp_tx = cur_byte[slot-1];
      end
      exp_full = (mq_data.size() == DEPTH);
      exp_busy = in_frame || (mq_data.size() != 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    repeat (3) step();
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
    checks++; if (ack !== 1'b0)  begin errors++; $display("FAIL reset_ack got %b want 0", ack); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL idle_tx cyc %0d got %b want 1", i, tx); end
      checks++; if (ack !== 1'b0)   begin errors++; $display("FAIL idle_ack cyc %0d got %b want 0", i, ack); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL idle_stall cyc %0d got %b want 0", i, stall); end
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL idle_busy cyc %0d got %b want 0", i, busy); end
    end
  endtask

  task automatic test_single_frame();
    int e0, t, rel;
    logic [9:0] frame;
    logic       want;
    frame   = {1'b1, 8'hA5, 1'b0};
    wb_cyc  = 1'b1;
    wb_stb  = 1'b1;
    wb_data = 8'hA5;
    step();
    e0     = cyc_cnt;
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    for (int k = 0; k < 60; k++) begin
      t    = cyc_cnt;
      rel  = t - (e0 + 2);
      want = (rel < 0 || rel >= 10 * N) ? 1'b1 : frame[rel / N];
      checks++; if (tx !== want) begin errors++; $display("FAIL single_tx E0+%0d got %b want %b", t - e0, tx, want); end
      checks++; if (ack !== (t == e0)) begin errors++; $display("FAIL single_ack E0+%0d got %b want %b", t - e0, ack, t == e0); end
      checks++; if (busy !== (t < e0 + 2 + 10 * N)) begin errors++; $display("FAIL single_busy E0+%0d got %b want %b", t - e0, busy, t < e0 + 2 + 10 * N); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int e0, s;
    logic [7:0] want [2];
    logic [7:0] got;
    want[0] = 8'h00;
    want[1] = 8'hFF;
    wb_cyc  = 1'b1;
    wb_stb  = 1'b1;
    wb_data = want[0];
    step();
    e0 = cyc_cnt;
    line_buf[0] = tx;
    wb_data = want[1];
    step();
    line_buf[1] = tx;
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL b2b_ack2 got %b want 1", ack); end
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    for (int k = 2; k < 115; k++) begin
      step();
      line_buf[cyc_cnt - e0] = tx;
      checks++; if (tx !== exp_tx)     begin errors++; $display("FAIL b2b_tx E0+%0d got %b want %b", cyc_cnt - e0, tx, exp_tx); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL b2b_busy E0+%0d got %b want %b", cyc_cnt - e0, busy, exp_busy); end
    end
    checks++; if (line_buf[2 + FRAME - 1] !== 1'b1) begin errors++; $display("FAIL b2b_gap got %b want 1", line_buf[2 + FRAME - 1]); end
    checks++; if (line_buf[2 + FRAME] !== 1'b0)     begin errors++; $display("FAIL b2b_start2 got %b want 0", line_buf[2 + FRAME]); end
    for (int f = 0; f < 2; f++) begin
      s = 2 + f * FRAME;
      for (int i = 0; i < 8; i++) got[i] = line_buf[s + (i + 1) * N + N / 2];
      checks++; if (line_buf[s + N / 2] !== 1'b0)     begin errors++; $display("FAIL b2b_startbit frame %0d got %b want 0", f, line_buf[s + N / 2]); end
      checks++; if (line_buf[s + 9 * N + N / 2] !== 1'b1) begin errors++; $display("FAIL b2b_stopbit frame %0d got %b want 1", f, line_buf[s + 9 * N + N / 2]); end
      checks++; if (got !== want[f]) begin errors++; $display("FAIL b2b_byte frame %0d got %02h want %02h", f, got, want[f]); end
    end
  endtask

  task automatic test_fifo_fill();
    int e0, acks, s;
    logic [7:0] sent [33];
    logic [7:0] got;
    acks   = 0;
    e0     = 0;
    wb_cyc = 1'b1;
    wb_stb = 1'b1;
    for (int i = 0; i < 34; i++) begin
      wb_data = 8'($urandom);
      if (i < 33) sent[i] = wb_data;
      if (i == 33) begin
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fill_stall got %b want 1", stall); end
        checks++; if (full !== 1'b1)  begin errors++; $display("FAIL fill_full got %b want 1", full); end
      end
      step();
      if (i == 0) e0 = cyc_cnt;
      line_buf[cyc_cnt - e0] = tx;
      if (ack === 1'b1) acks++;
      checks++; if (ack !== (i < 33)) begin errors++; $display("FAIL fill_ack attempt %0d got %b want %b", i, ack, i < 33); end
    end
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    checks++; if (acks != 33) begin errors++; $display("FAIL fill_ack_count got %0d want 33", acks); end
    while (cyc_cnt < e0 + 2 + 33 * FRAME + 10) begin
      step();
      line_buf[cyc_cnt - e0] = tx;
      if (cyc_cnt == e0 + 2 + FRAME - 1) begin
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fill_stall_hold got %b want 1", stall); end
      end
      if (cyc_cnt == e0 + 2 + FRAME) begin
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fill_stall_drop got %b want 0", stall); end
      end
      checks++; if (tx !== exp_tx)       begin errors++; $display("FAIL fill_tx E0+%0d got %b want %b", cyc_cnt - e0, tx, exp_tx); end
      checks++; if (stall !== exp_full)  begin errors++; $display("FAIL fill_stall E0+%0d got %b want %b", cyc_cnt - e0, stall, exp_full); end
      checks++; if (busy !== exp_busy)   begin errors++; $display("FAIL fill_busy E0+%0d got %b want %b", cyc_cnt - e0, busy, exp_busy); end
    end
    for (int f = 0; f < 33; f++) begin
      s = 2 + f * FRAME;
      for (int i = 0; i < 8; i++) got[i] = line_buf[s + (i + 1) * N + N / 2];
      checks++; if (got !== sent[f]) begin errors++; $display("FAIL fill_byte frame %0d got %02h want %02h", f, got, sent[f]); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fill_drained got %b want 0", busy); end
  endtask

  task automatic test_no_cyc();
    wb_cyc = 1'b0;
    wb_stb = 1'b1;
    for (int i = 0; i < 12; i++) begin
      wb_data = 8'($urandom);
      step();
      checks++; if (ack !== 1'b0)   begin errors++; $display("FAIL nocyc_ack cyc %0d got %b want 0", i, ack); end
      checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL nocyc_tx cyc %0d got %b want 1", i, tx); end
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL nocyc_busy cyc %0d got %b want 0", i, busy); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nocyc_stall cyc %0d got %b want 0", i, stall); end
    end
    wb_stb = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int e0;
    wb_cyc  = 1'b1;
    wb_stb  = 1'b1;
    wb_data = 8'h3C;
    step();
    e0 = cyc_cnt;
    for (int i = 0; i < 4; i++) begin
      wb_data = 8'($urandom);
      step();
    end
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    while (cyc_cnt < e0 + 2 + 4 * N + 2) begin
      step();
      checks++; if (tx !== exp_tx) begin errors++; $display("FAIL rmid_tx E0+%0d got %b want %b", cyc_cnt - e0, tx, exp_tx); end
    end
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL rmid_bit3 got %b want 1", tx); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_pre got %b want 1", busy); end
    rst_n = 1'b0;
    step();
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL rmid_tx_reset got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy_reset got %b want 0", busy); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rmid_full_reset got %b want 0", full); end
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL rmid_tx_after cyc %0d got %b want 1", i, tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy_after cyc %0d got %b want 0", i, busy); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 900; i++) begin
      wb_cyc  = ($urandom_range(0, 3) != 0);
      wb_stb  = $urandom_range(0, 1) == 1;
      wb_data = 8'($urandom);
      step();
      checks++; if (ack !== exp_ack)   begin errors++; $display("FAIL rand_ack t=%0d got %b want %b", cyc_cnt, ack, exp_ack); end
      checks++; if (tx !== exp_tx)     begin errors++; $display("FAIL rand_tx t=%0d got %b want %b", cyc_cnt, tx, exp_tx); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rand_busy t=%0d got %b want %b", cyc_cnt, busy, exp_busy); end
      checks++; if (stall !== exp_full) begin errors++; $display("FAIL rand_stall t=%0d got %b want %b", cyc_cnt, stall, exp_full); end
      checks++; if (full !== exp_full) begin errors++; $display("FAIL rand_full t=%0d got %b want %b", cyc_cnt, full, exp_full); end
    end
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    for (int i = 0; i < 1800; i++) begin
      step();
      checks++; if (tx !== exp_tx)     begin errors++; $display("FAIL drain_tx t=%0d got %b want %b", cyc_cnt, tx, exp_tx); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL drain_busy t=%0d got %b want %b", cyc_cnt, busy, exp_busy); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_done got %b want 0", busy); end
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL drain_idle_tx got %b want 1", tx); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_fifo_fill();
    test_no_cyc();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
